// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdivinv_p.sv
// gf180mcu_osu_sc_gp12t3v3__clkdivinv_p: glitch-free programmable 50%-duty clock divider with polarity select
module gf180mcu_osu_sc_gp12t3v3__clkdivinv_p #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             INV,
    output logic             Y,
    output logic             TC,
    output logic             BUSY
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam logic [WIDTH-1:0] ONE = 1;
    state_t state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
    logic inv_q, inv_d, y_q, tc_q, busy_q, last;
    assign last = cnt_q == div_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + ONE;
        div_d = div_q;
        inv_d = inv_q;
        case (state_q)
            IDLE: begin
                div_d = DIV;
                inv_d = INV;
                cnt_d = '0;
                state_d = EN ? HIGH : IDLE;
            end
            HIGH: if (last) begin
                cnt_d = '0;
                state_d = LOW;
            end
            LOW: if (last) begin
                cnt_d = '0;
                div_d = EN ? DIV : div_q;
                state_d = EN ? HIGH : IDLE;
            end
            default: begin
                cnt_d = '0;
                state_d = IDLE;
            end
        endcase
    end
    // outputs are registered from next-state values so they align with the state they describe
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q <= '0;
            div_q <= '0;
            inv_q <= 1'b0;
            y_q <= 1'b0;
            tc_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
            inv_q <= inv_d;
            y_q <= (state_d == HIGH) ^ inv_d;
            tc_q <= (state_d == HIGH) && (state_q != HIGH);
            busy_q <= state_d != IDLE;
        end
    end
    assign Y = y_q;
    assign TC = tc_q;
    assign BUSY = busy_q;
endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__clkdivinv_p.sv
// tb_gf180mcu_osu_sc_gp12t3v3__clkdivinv_p: directed cycle-by-cycle checks of {Y,TC,BUSY}
module tb_gf180mcu_osu_sc_gp12t3v3__clkdivinv_p;
    logic CLK = 1'b0, RN = 1'b0, EN = 1'b0, INV = 1'b0;
    logic [3:0] DIV = '0;
    logic Y, TC, BUSY;
    int checks = 0, errors = 0;
    gf180mcu_osu_sc_gp12t3v3__clkdivinv_p #(.WIDTH(4)) dut (
        .CLK(CLK), .RN(RN), .EN(EN), .DIV(DIV), .INV(INV), .Y(Y), .TC(TC), .BUSY(BUSY)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: {Y,TC,BUSY} got %b expected %b", tag, got, exp);
        end
    endtask
    task automatic cyc(input string tag, input logic en, input logic [3:0] d, input logic inv, input logic [2:0] exp);
        EN = en;
        DIV = d;
        INV = inv;
        @(posedge CLK);
        #1;
        chk(tag, {Y, TC, BUSY}, exp);
    endtask
    initial begin
        EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("reset_hold", {Y, TC, BUSY}, 3'b000);
        end
        RN = 1'b1;
        cyc("rel_idle0", 0, 0, 0, 3'b000);
        cyc("rel_idle1", 0, 0, 0, 3'b000);
        // DIV=0: CLK/2
        cyc("d0_e1", 1, 0, 0, 3'b111);
        cyc("d0_e2", 1, 0, 0, 3'b001);
        cyc("d0_e3", 1, 0, 0, 3'b111);
        cyc("d0_e4", 1, 0, 0, 3'b001);
        cyc("d0_stop", 0, 0, 0, 3'b000);
        cyc("d0_idle", 0, 0, 0, 3'b000);
        // DIV=3 then DIV=1 mid-HIGH
        cyc("d3_e1", 1, 3, 0, 3'b111);
        cyc("d3_e2", 1, 1, 0, 3'b101);
        cyc("d3_e3", 1, 1, 0, 3'b101);
        cyc("d3_e4", 1, 1, 0, 3'b101);
        cyc("d3_e5", 1, 1, 0, 3'b001);
        cyc("d3_e6", 1, 1, 0, 3'b001);
        cyc("d3_e7", 1, 1, 0, 3'b001);
        cyc("d3_e8", 1, 1, 0, 3'b001);
        cyc("d1_e9", 1, 1, 0, 3'b111);
        cyc("d1_e10", 1, 1, 0, 3'b101);
        cyc("d1_e11", 1, 1, 0, 3'b001);
        cyc("d1_e12", 1, 1, 0, 3'b001);
        cyc("d1_e13", 1, 1, 0, 3'b111);
        cyc("d1_e14", 0, 1, 0, 3'b101);
        cyc("d1_e15", 0, 1, 0, 3'b001);
        cyc("d1_e16", 0, 1, 0, 3'b001);
        cyc("d1_idle", 0, 1, 0, 3'b000);
        // DIV=2, EN dropped on 2nd HIGH cycle
        cyc("stop_e1", 1, 2, 0, 3'b111);
        cyc("stop_e2", 0, 2, 0, 3'b101);
        cyc("stop_e3", 0, 2, 0, 3'b101);
        cyc("stop_e4", 0, 2, 0, 3'b001);
        cyc("stop_e5", 0, 2, 0, 3'b001);
        cyc("stop_e6", 0, 2, 0, 3'b001);
        cyc("stop_idle", 0, 2, 0, 3'b000);
        cyc("stop_idle2", 0, 2, 0, 3'b000);
        // inverted polarity, INV toggled while running
        cyc("inv_idle", 0, 1, 1, 3'b100);
        cyc("inv_e1", 1, 1, 1, 3'b011);
        cyc("inv_e2", 1, 1, 0, 3'b001);
        cyc("inv_e3", 1, 1, 1, 3'b101);
        cyc("inv_e4", 1, 1, 0, 3'b101);
        cyc("inv_e5", 1, 1, 1, 3'b011);
        cyc("inv_e6", 0, 1, 0, 3'b001);
        cyc("inv_e7", 0, 1, 0, 3'b101);
        cyc("inv_e8", 0, 1, 1, 3'b101);
        cyc("inv_park", 0, 1, 1, 3'b100);
        cyc("inv_reload", 0, 1, 0, 3'b000);
        // DIV=5, reset pulsed during LOW
        cyc("d5_e1", 1, 5, 0, 3'b111);
        for (int i = 0; i < 5; i++) cyc("d5_high", 1, 5, 0, 3'b101);
        cyc("d5_low1", 1, 5, 0, 3'b001);
        cyc("d5_low2", 1, 5, 0, 3'b001);
        RN = 1'b0;
        #1;
        chk("rst_async", {Y, TC, BUSY}, 3'b000);
        @(posedge CLK);
        #1;
        chk("rst_held", {Y, TC, BUSY}, 3'b000);
        RN = 1'b1;
        cyc("rr_e1", 1, 5, 0, 3'b111);
        for (int i = 0; i < 5; i++) cyc("rr_high", 1, 5, 0, 3'b101);
        cyc("rr_low", 1, 5, 0, 3'b001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
